// File: rtl/iir_ctrl_pkg.sv
// Shared definitions for the IIR filter control slice: sequencer states,
// tap register addresses and the tap word width.
package iir_ctrl_pkg;

    localparam int TAP_W = 35;

    localparam logic [1:0] ADDR_A1 = 2'd0;
    localparam logic [1:0] ADDR_B0 = 2'd1;
    localparam logic [1:0] ADDR_B1 = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        RUN    = 2'd2,
        WINDUP = 2'd3
    } iir_state_e;

endpackage

// File: rtl/iir_tap_bank.sv
// Double-buffered a1/b0/b1 taps: host writes land in shadow registers and a
// commit strobe copies all three into the active set on a single edge.
module iir_tap_bank
    import iir_ctrl_pkg::*;
(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    wr_en_in,
    input  logic [1:0]              wr_addr_in,
    input  logic signed [TAP_W-1:0] wr_data_in,
    input  logic                    commit_in,
    output logic signed [TAP_W-1:0] a1_out,
    output logic signed [TAP_W-1:0] b0_out,
    output logic signed [TAP_W-1:0] b1_out,
    output logic                    pending_out
);

    // Handshake: wr_en_in and commit_in are single-cycle strobes with no
    // back-pressure; every strobe sampled high on a rising edge is accepted.
    logic signed [TAP_W-1:0] sh_a1;
    logic signed [TAP_W-1:0] sh_b0;
    logic signed [TAP_W-1:0] sh_b1;
    logic                    wr_valid;

    assign wr_valid = wr_en_in && (wr_addr_in != 2'd3);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sh_a1       <= '0;
            sh_b0       <= '0;
            sh_b1       <= '0;
            a1_out      <= '0;
            b0_out      <= '0;
            b1_out      <= '0;
            pending_out <= 1'b0;
        end else begin
            if (wr_en_in) begin
                case (wr_addr_in)
                    ADDR_A1: sh_a1 <= wr_data_in;
                    ADDR_B0: sh_b0 <= wr_data_in;
                    ADDR_B1: sh_b1 <= wr_data_in;
                    default: ;
                endcase
            end
            // Non-blocking copy means a same-edge write is not seen by the commit.
            if (commit_in) begin
                a1_out <= sh_a1;
                b0_out <= sh_b0;
                b1_out <= sh_b1;
            end
            if (wr_valid) begin
                pending_out <= 1'b1;
            end else if (commit_in) begin
                pending_out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/iir_tap_sequencer.sv
// Sequences the IIR filter's on input through flush intervals on enable and
// on flushing commits, and forces a timed filter reset when the output rails.
module iir_tap_sequencer
    import iir_ctrl_pkg::*;
#(
    parameter int SIGNAL_OUT_SIZE = 16,
    parameter int FLUSH_CYCLES    = 4,
    parameter int RAIL_LIMIT      = 1024
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              en_in,
    input  logic                              wr_en_in,
    input  logic [1:0]                        wr_addr_in,
    input  logic signed [TAP_W-1:0]           wr_data_in,
    input  logic                              commit_in,
    input  logic                              flush_on_commit_in,
    input  logic signed [SIGNAL_OUT_SIZE-1:0] filter_out_in,
    output logic signed [TAP_W-1:0]           a1_out,
    output logic signed [TAP_W-1:0]           b0_out,
    output logic signed [TAP_W-1:0]           b1_out,
    output logic                              on_out,
    output logic                              pending_out,
    output logic                              rail_event_out,
    output logic [15:0]                       rail_count_out,
    output iir_state_e                        state_out
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [SIGNAL_OUT_SIZE-1:0] RAIL_HI = {1'b0, {(SIGNAL_OUT_SIZE-1){1'b1}}};
    localparam logic [SIGNAL_OUT_SIZE-1:0] RAIL_LO = {1'b1, {(SIGNAL_OUT_SIZE-1){1'b0}}};
    localparam logic [15:0] RUN_LAST = 16'(RAIL_LIMIT - 1);

    iir_state_e       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [15:0]      run_cnt, run_cnt_next;
    logic             at_rail;
    logic             rail_trig;

    iir_tap_bank u_tap_bank (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .wr_en_in    (wr_en_in),
        .wr_addr_in  (wr_addr_in),
        .wr_data_in  (wr_data_in),
        .commit_in   (commit_in),
        .a1_out      (a1_out),
        .b0_out      (b0_out),
        .b1_out      (b1_out),
        .pending_out (pending_out)
    );

    assign state_out = state;
    assign at_rail   = (filter_out_in == RAIL_HI) || (filter_out_in == RAIL_LO);

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        rail_trig    = 1'b0;
        run_cnt_next = '0;
        if ((RAIL_LIMIT != 0) && (state == RUN) && en_in && at_rail && (run_cnt == RUN_LAST)) begin
            rail_trig = 1'b1;
        end
        case (state)
            IDLE: begin
                if (en_in) begin
                    state_next = PRIME;
                    cnt_next   = CNT_LOAD;
                end
            end
            PRIME, WINDUP: begin
                // Commits here swap taps but deliberately leave the count alone.
                if (cnt == '0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RUN: begin
                if (rail_trig) begin
                    state_next = WINDUP;
                    cnt_next   = CNT_LOAD;
                end else if (commit_in && flush_on_commit_in) begin
                    state_next = PRIME;
                    cnt_next   = CNT_LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!en_in) begin
            state_next = IDLE;
        end
        if ((RAIL_LIMIT != 0) && (state == RUN) && (state_next == RUN) && at_rail) begin
            run_cnt_next = run_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            cnt            <= '0;
            run_cnt        <= '0;
            on_out         <= 1'b0;
            rail_event_out <= 1'b0;
            rail_count_out <= '0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            run_cnt        <= run_cnt_next;
            on_out         <= (state_next == RUN);
            rail_event_out <= rail_trig;
            if (rail_trig && (rail_count_out != 16'hFFFF)) begin
                rail_count_out <= rail_count_out + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_iir_tap_sequencer.sv
// Directed bench for iir_tap_sequencer: a vector table for tap write/commit
// rules plus hand-written sequences for flush, anti-windup and reset timing.
module tb_iir_tap_sequencer;
    import iir_ctrl_pkg::*;

    localparam int SW = 16;
    localparam int FC = 4;
    localparam int RL = 8;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 en_in;
    logic                 wr_en_in;
    logic [1:0]           wr_addr_in;
    logic [TAP_W-1:0]     wr_data_in;
    logic                 commit_in;
    logic                 flush_on_commit_in;
    logic [SW-1:0]        filter_out_in;
    logic [TAP_W-1:0]     a1_out, b0_out, b1_out;
    logic                 on_out, pending_out, rail_event_out;
    logic [15:0]          rail_count_out;
    iir_state_e           state_dbg;

    int n_vec = 0;
    int n_err = 0;
    logic [0:0] exp_q[$];

    typedef struct {
        logic             wr;
        logic [1:0]       addr;
        logic [TAP_W-1:0] data;
        logic             commit;
        logic             pend;
        logic [TAP_W-1:0] a1, b0, b1;
    } vec_t;

    vec_t vecs[9];

    // Clock / reset
    always #5 clk_in = ~clk_in;

    iir_tap_sequencer #(
        .SIGNAL_OUT_SIZE (SW),
        .FLUSH_CYCLES    (FC),
        .RAIL_LIMIT      (RL)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .en_in              (en_in),
        .wr_en_in           (wr_en_in),
        .wr_addr_in         (wr_addr_in),
        .wr_data_in         (wr_data_in),
        .commit_in          (commit_in),
        .flush_on_commit_in (flush_on_commit_in),
        .filter_out_in      (filter_out_in),
        .a1_out             (a1_out),
        .b0_out             (b0_out),
        .b1_out             (b1_out),
        .on_out             (on_out),
        .pending_out        (pending_out),
        .rail_event_out     (rail_event_out),
        .rail_count_out     (rail_count_out),
        .state_out          (state_dbg)
    );

    function automatic vec_t mk(logic wr, logic [1:0] addr, logic [TAP_W-1:0] data, logic commit,
                                logic pend, logic [TAP_W-1:0] a1, logic [TAP_W-1:0] b0,
                                logic [TAP_W-1:0] b1);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.commit = commit;
        v.pend = pend; v.a1 = a1; v.b0 = b0; v.b1 = b1;
        return v;
    endfunction

    // Scoreboard
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic strobes_off();
        wr_en_in  = 1'b0;
        commit_in = 1'b0;
        flush_on_commit_in = 1'b0;
    endtask

    task automatic write_tap(input logic [1:0] addr, input logic [TAP_W-1:0] data);
        wr_en_in   = 1'b1;
        wr_addr_in = addr;
        wr_data_in = data;
        step();
        wr_en_in   = 1'b0;
    endtask

    task automatic run_q(input string name);
        while (exp_q.size() > 0) begin
            step();
            check(name, 64'(on_out), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic push_on(input int n, input logic v);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    initial begin
        rst_in = 1'b1;
        en_in = 1'b0;
        wr_addr_in = '0;
        wr_data_in = '0;
        filter_out_in = '0;
        strobes_off();

        vecs[0] = mk(1, ADDR_A1, 35'h000000400, 0, 1, 35'h0,   35'h0,   35'h0);
        vecs[1] = mk(1, ADDR_B0, 35'h000000200, 0, 1, 35'h0,   35'h0,   35'h0);
        vecs[2] = mk(1, ADDR_B1, 35'h7FFFFFFFF, 0, 1, 35'h0,   35'h0,   35'h0);
        vecs[3] = mk(0, 2'd0,    35'h0,         1, 0, 35'h400, 35'h200, 35'h7FFFFFFFF);
        vecs[4] = mk(1, 2'd3,    35'h123,       0, 0, 35'h400, 35'h200, 35'h7FFFFFFFF);
        vecs[5] = mk(1, ADDR_B0, 35'h3,         0, 1, 35'h400, 35'h200, 35'h7FFFFFFFF);
        vecs[6] = mk(0, 2'd0,    35'h0,         1, 0, 35'h400, 35'h3,   35'h7FFFFFFFF);
        vecs[7] = mk(1, ADDR_B0, 35'h5,         1, 1, 35'h400, 35'h3,   35'h7FFFFFFFF);
        vecs[8] = mk(0, 2'd0,    35'h0,         1, 0, 35'h400, 35'h5,   35'h7FFFFFFFF);

        #2;
        check("rst_a1", 64'(a1_out), 64'h0);
        check("rst_on", 64'(on_out), 64'h0);
        check("rst_pending", 64'(pending_out), 64'h0);
        check("rst_rail_cnt", 64'(rail_count_out), 64'h0);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        step();
        step();
        rst_in = 1'b0;

        // Tap write/commit rules, one vector per clock
        for (int i = 0; i < 9; i++) begin
            wr_en_in   = vecs[i].wr;
            wr_addr_in = vecs[i].addr;
            wr_data_in = vecs[i].data;
            commit_in  = vecs[i].commit;
            step();
            check($sformatf("vec%0d_a1", i), 64'(a1_out), 64'(vecs[i].a1));
            check($sformatf("vec%0d_b0", i), 64'(b0_out), 64'(vecs[i].b0));
            check($sformatf("vec%0d_b1", i), 64'(b1_out), 64'(vecs[i].b1));
            check($sformatf("vec%0d_pending", i), 64'(pending_out), 64'(vecs[i].pend));
            check($sformatf("vec%0d_on", i), 64'(on_out), 64'h0);
        end
        strobes_off();

        // Enable: four PRIME cycles then RUN; drop enable -> off next edge
        en_in = 1'b1;
        push_on(FC, 1'b0);
        push_on(16, 1'b1);
        run_q("en_rise");
        en_in = 1'b0;
        push_on(2, 1'b0);
        run_q("en_fall");

        // Flushing commit in RUN
        en_in = 1'b1;
        push_on(FC, 1'b0);
        push_on(3, 1'b1);
        run_q("prime2");
        write_tap(ADDR_A1, 35'h10);
        check("run_wr_pending", 64'(pending_out), 64'h1);
        check("run_wr_a1_hold", 64'(a1_out), 64'h400);
        commit_in = 1'b1;
        flush_on_commit_in = 1'b1;
        step();
        strobes_off();
        check("flush_commit_a1", 64'(a1_out), 64'h10);
        check("flush_commit_on", 64'(on_out), 64'h0);
        check("flush_commit_pending", 64'(pending_out), 64'h0);
        push_on(FC - 1, 1'b0);
        push_on(2, 1'b1);
        run_q("flush_on");

        // Non-flushing commit in RUN keeps the filter on
        write_tap(ADDR_B1, 35'h22);
        commit_in = 1'b1;
        step();
        strobes_off();
        check("noflush_b1", 64'(b1_out), 64'h22);
        check("noflush_on", 64'(on_out), 64'h1);
        push_on(2, 1'b1);
        run_q("noflush_stay");

        // Anti-windup: eight consecutive max-positive samples
        filter_out_in = 16'h7FFF;
        for (int i = 0; i < RL - 1; i++) begin
            step();
            check("rail_pre_event", 64'(rail_event_out), 64'h0);
        end
        step();
        check("rail_event", 64'(rail_event_out), 64'h1);
        check("rail_on_drop", 64'(on_out), 64'h0);
        check("rail_count1", 64'(rail_count_out), 64'h1);
        check("rail_state", 64'(state_dbg), 64'(WINDUP));
        filter_out_in = '0;
        step();
        check("rail_pulse_end", 64'(rail_event_out), 64'h0);
        check("windup_on1", 64'(on_out), 64'h0);
        push_on(FC - 2, 1'b0);
        push_on(2, 1'b1);
        run_q("windup_on");

        // Seven rail samples broken by 0x7FFE: no trigger
        for (int i = 0; i < 16; i++) begin
            filter_out_in = (i == 7) ? 16'h7FFE : (i == 15) ? 16'h0000 : 16'h7FFF;
            step();
            check("rail_broken", 64'(rail_event_out), 64'h0);
        end
        check("rail_broken_cnt", 64'(rail_count_out), 64'h1);
        check("rail_broken_on", 64'(on_out), 64'h1);

        // Min-negative rail also triggers
        filter_out_in = 16'h8000;
        for (int i = 0; i < RL; i++) step();
        check("rail_neg_event", 64'(rail_event_out), 64'h1);
        check("rail_count2", 64'(rail_count_out), 64'h2);
        filter_out_in = '0;

        // Asynchronous reset in WINDUP, then restart with en_in held high
        rst_in = 1'b1;
        #2;
        check("arst_a1", 64'(a1_out), 64'h0);
        check("arst_b1", 64'(b1_out), 64'h0);
        check("arst_on", 64'(on_out), 64'h0);
        check("arst_rail_cnt", 64'(rail_count_out), 64'h0);
        check("arst_event", 64'(rail_event_out), 64'h0);
        check("arst_state", 64'(state_dbg), 64'(IDLE));
        step();
        rst_in = 1'b0;
        push_on(FC, 1'b0);
        push_on(2, 1'b1);
        run_q("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
